// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared widths, reset PC and helpers
// for the instruction fetch stage.
package ifetch_pkg;

  localparam int BUS_W = 32;
  localparam int DATA_W = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int INSTR_BYTES = 4;
  localparam int QDEPTH = 2;

  function automatic logic [1:0] cnt2(
    input logic [1:0] v
  );
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/ifetch_unit_fetch_queue.sv
// fetch_queue: 2-slot in-order alloc/fill/pop
// queue for outstanding instruction fetches.
module fetch_queue
  import ifetch_pkg::*;
#(
  parameter int BW = BUS_W,
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [BW-1:0] push_pc_i,
  input  logic          push_bt_i,
  input  logic [BW-1:0] push_tgt_i,
  input  logic          fill_i,
  input  logic [DW-1:0] fill_data_i,
  input  logic          pop_i,
  output logic          valid_o,
  output logic [BW-1:0] head_pc_o,
  output logic [DW-1:0] head_instr_o,
  output logic          head_bt_o,
  output logic [BW-1:0] head_tgt_o,
  output logic [1:0]    alloc_cnt_o,
  output logic [1:0]    pend_cnt_o
);

  logic [1:0]    alloc_q;
  logic [1:0]    done_q;
  logic          head_q;
  logic          tail_q;
  logic [BW-1:0] pc_q    [QDEPTH];
  logic          bt_q    [QDEPTH];
  logic [BW-1:0] tgt_q   [QDEPTH];
  logic [DW-1:0] instr_q [QDEPTH];

  logic [1:0] pend_vec;
  logic       fill_sel;
  logic       fill_ok;

  assign pend_vec = alloc_q & ~done_q;

  // Responses return in order: the head is older
  // than the other slot whenever both are pending.
  always_comb begin
    fill_ok  = 1'b1;
    fill_sel = head_q;
    if (pend_vec[head_q]) begin
      fill_sel = head_q;
    end else if (pend_vec[~head_q]) begin
      fill_sel = ~head_q;
    end else begin
      fill_ok = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alloc_q <= '0;
      done_q  <= '0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) begin
        pc_q[i]    <= '0;
        bt_q[i]    <= 1'b0;
        tgt_q[i]   <= '0;
        instr_q[i] <= '0;
      end
    end else if (flush_i) begin
      alloc_q <= '0;
      done_q  <= '0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
    end else begin
      if (pop_i) begin
        alloc_q[head_q] <= 1'b0;
        done_q[head_q]  <= 1'b0;
        head_q          <= ~head_q;
      end
      // On a full queue push reuses the slot
      // that pop frees in the same cycle.
      if (push_i) begin
        alloc_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        pc_q[tail_q]    <= push_pc_i;
        bt_q[tail_q]    <= push_bt_i;
        tgt_q[tail_q]   <= push_tgt_i;
        tail_q          <= ~tail_q;
      end
      if (fill_i && fill_ok) begin
        done_q[fill_sel]  <= 1'b1;
        instr_q[fill_sel] <= fill_data_i;
      end
    end
  end

  assign valid_o      = alloc_q[head_q] & done_q[head_q];
  assign head_pc_o    = pc_q[head_q];
  assign head_instr_o = instr_q[head_q];
  assign head_bt_o    = bt_q[head_q];
  assign head_tgt_o   = tgt_q[head_q];
  assign alloc_cnt_o  = cnt2(alloc_q);
  assign pend_cnt_o   = cnt2(pend_vec);

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: fetch PC, imem request issue and
// stale-response discard in front of the IF/ID register.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int BUS_WIDTH = BUS_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter logic [BUS_WIDTH-1:0] RESET_PC =
    BUS_WIDTH'(RESET_PC_DEF)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cancel,
  input  logic [BUS_WIDTH-1:0]  redirect_pc,
  output logic                  imem_req,
  output logic [BUS_WIDTH-1:0]  imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  bp_taken_req,
  input  logic [BUS_WIDTH-1:0]  bp_target_req,
  input  logic                  allow_in_id,
  output logic                  valid_if,
  output logic                  ready_go_if,
  output logic [BUS_WIDTH-1:0]  pc_if,
  output logic [DATA_WIDTH-1:0] instruction_if,
  output logic                  bp_taken_if,
  output logic [BUS_WIDTH-1:0]  pre_taken_target_if
);

  logic [BUS_WIDTH-1:0] fpc_q;
  logic [BUS_WIDTH-1:0] fpc_d;
  logic [1:0]           discard_q;
  logic [1:0]           discard_d;

  logic       accept;
  logic       pop;
  logic       fill;
  logic       q_valid;
  logic [1:0] alloc_cnt;
  logic [1:0] pend_cnt;
  logic [2:0] occ;
  logic [2:0] dsum;

  assign occ = {1'b0, alloc_cnt} + {1'b0, discard_q};
  assign pop = q_valid & allow_in_id & ~cancel;

  // A same-cycle pop frees a slot, so a full
  // queue can still issue while ID drains it.
  assign imem_req = rst_n & ~cancel &
                    (occ < (pop ? 3'd3 : 3'd2));
  assign imem_addr = fpc_q;
  assign accept = imem_req & imem_gnt;
  assign fill = imem_rvalid & (discard_q == 2'd0) &
                ~cancel;

  assign dsum = {1'b0, discard_q} + {1'b0, pend_cnt};

  always_comb begin
    fpc_d = fpc_q;
    if (cancel) begin
      fpc_d = redirect_pc;
    end else if (accept) begin
      fpc_d = bp_taken_req ? bp_target_req :
              fpc_q + BUS_WIDTH'(INSTR_BYTES);
    end
  end

  // Every fetch still in flight at a redirect
  // owes one response that must be dropped.
  always_comb begin
    discard_d = discard_q;
    if (cancel) begin
      if (imem_rvalid && dsum != 3'd0) begin
        discard_d = 2'(dsum - 3'd1);
      end else begin
        discard_d = 2'(dsum);
      end
    end else if (imem_rvalid && discard_q != 2'd0) begin
      discard_d = discard_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fpc_q     <= RESET_PC;
      discard_q <= 2'd0;
    end else begin
      fpc_q     <= fpc_d;
      discard_q <= discard_d;
    end
  end

  fetch_queue #(
    .BW (BUS_WIDTH),
    .DW (DATA_WIDTH)
  ) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (cancel),
    .push_i       (accept),
    .push_pc_i    (fpc_q),
    .push_bt_i    (bp_taken_req),
    .push_tgt_i   (bp_target_req),
    .fill_i       (fill),
    .fill_data_i  (imem_rdata),
    .pop_i        (pop),
    .valid_o      (q_valid),
    .head_pc_o    (pc_if),
    .head_instr_o (instruction_if),
    .head_bt_o    (bp_taken_if),
    .head_tgt_o   (pre_taken_target_if),
    .alloc_cnt_o  (alloc_cnt),
    .pend_cnt_o   (pend_cnt)
  );

  assign valid_if    = q_valid;
  assign ready_go_if = q_valid;

  a_rvalid_owned: assert property (
    @(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (discard_q != 2'd0 || pend_cnt != 2'd0)
  );

endmodule
